// File: rtl/pool_pair_feeder_if.sv
// Handshake bundle between the pixel source, the pool pair feeder and the comparator.
// Optional err_frame signal exists only when POOL_FEEDER_ERR_EN is defined.
interface pool_pair_feeder_if #(
  parameter int DATA_WIDTH = 20
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  pair_valid;
  logic                  pair_ready;
  logic [DATA_WIDTH-1:0] pair_data0;
  logic [DATA_WIDTH-1:0] pair_data1;
  logic                  pair_row_end;
`ifdef POOL_FEEDER_ERR_EN
  logic                  err_frame;
`endif

  // master: the feeder itself (consumes pixels, produces pairs)
  modport master (
    input  in_valid, in_data, in_last, pair_ready,
    output in_ready, pair_valid, pair_data0, pair_data1, pair_row_end
`ifdef POOL_FEEDER_ERR_EN
    , output err_frame
`endif
  );

  modport slave (
    output in_valid, in_data, in_last, pair_ready,
    input  in_ready, pair_valid, pair_data0, pair_data1, pair_row_end
`ifdef POOL_FEEDER_ERR_EN
    , input err_frame
`endif
  );
endinterface

// File: rtl/pool_pair_feeder.sv
// Buffers an even row and pairs each odd-row pixel with the buffered pixel above it.
// Latency 1 cycle lower pixel -> pair; back-pressure only in PAIR. Optional POOL_FEEDER_ERR_EN adds err_frame.
module pool_pair_feeder #(
  parameter int DATA_WIDTH = 20,
  parameter int ROW_LEN    = 8
) (
  input  logic               clk,
  input  logic               rst,
  pool_pair_feeder_if.master bus
);
  localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_PAIR = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [DATA_WIDTH-1:0] buf_q [ROW_LEN];
  logic                  pair_valid_q, pair_valid_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic                  row_end_q, row_end_d;
  logic                  in_ready;
  logic                  accept;
  logic                  col_last;

  assign col_last = (col_q == COL_LAST);
  assign in_ready = !rst && ((state_q == S_FILL) || !pair_valid_q || bus.pair_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    pair_valid_d = pair_valid_q && !bus.pair_ready;
    data0_d      = data0_q;
    data1_d      = data1_q;
    row_end_d    = row_end_q;
    if (accept) begin
      col_d = col_last ? '0 : col_q + COL_W'(1);
      if (state_q == S_FILL) begin
        state_d = col_last ? S_PAIR : S_FILL;
      end else begin
        data0_d      = buf_q[col_q];
        data1_d      = bus.in_data;
        row_end_d    = col_last;
        pair_valid_d = 1'b1;
        state_d      = col_last ? S_FILL : S_PAIR;
      end
      // in_last realigns to the top of an upper row whatever the position
      if (bus.in_last) begin
        col_d   = '0;
        state_d = S_FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FILL;
      col_q        <= '0;
      pair_valid_q <= 1'b0;
      data0_q      <= '0;
      data1_q      <= '0;
      row_end_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      pair_valid_q <= pair_valid_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      row_end_q    <= row_end_d;
    end
  end

  // Row buffer is never cleared: FILL rewrites every column before PAIR reads it.
  always_ff @(posedge clk) begin
    if (accept && (state_q == S_FILL)) begin
      buf_q[col_q] <= bus.in_data;
    end
  end

`ifdef POOL_FEEDER_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q || (accept && bus.in_last && !((state_q == S_PAIR) && col_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_frame = err_q;
`endif

  assign bus.in_ready     = in_ready;
  assign bus.pair_valid   = pair_valid_q;
  assign bus.pair_data0   = data0_q;
  assign bus.pair_data1   = data1_q;
  assign bus.pair_row_end = row_end_q;
endmodule
